// File: rtl/hart_mailbox.sv
// Inter-hart mailbox unit: one FIFO per hardware thread, written by SEND stores
// and drained by the owning hart's RECV loads; blocked accesses stall the requester.
module hart_mailbox #(
    parameter int N_HARTS = 4,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 8,
    localparam int HW     = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DW-1:0]       wdata,
    input  logic [HW-1:0]       src_hart,
    input  logic                flush,
    output logic                stall,
    output logic [DW-1:0]       rdata,
    output logic                rvalid,
    output logic [N_HARTS-1:0]  full,
    output logic [N_HARTS-1:0]  empty,
    output logic [N_HARTS-1:0]  led
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] RECV_ADDR = ADDR_W'(N_HARTS);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(N_HARTS + 1);
    localparam logic [ADDR_W-1:0] CLR_ADDR  = ADDR_W'(N_HARTS + 2);

    logic [DW-1:0] mem    [N_HARTS][DEPTH];
    logic [PW-1:0] wr_ptr [N_HARTS];
    logic [PW-1:0] rd_ptr [N_HARTS];
    logic [CW-1:0] count  [N_HARTS];

    logic          is_read;
    logic          is_send;
    logic          is_recv;
    logic          is_stat;
    logic          is_other_rd;
    logic          is_clr;
    logic          src_ok;
    logic          accept;
    logic [HW-1:0] target;
    logic [HW-1:0] clr_idx;
    logic [DW-1:0] status_word;

    always_comb begin
        for (int k = 0; k < N_HARTS; k++) begin
            full[k]  = (count[k] == CW'(DEPTH));
            empty[k] = (count[k] == '0);
        end
    end

    // A simultaneous read and write is a write; the read half is dropped.
    always_comb begin
        target      = addr[HW-1:0];
        src_ok      = (32'(src_hart) < N_HARTS);
        is_read     = rd_en && !wr_en;
        is_send     = wr_en && (addr < RECV_ADDR);
        is_clr      = wr_en && (addr == CLR_ADDR);
        is_recv     = is_read && (addr == RECV_ADDR) && src_ok;
        is_stat     = is_read && (addr == STAT_ADDR);
        is_other_rd = is_read && !is_recv && !is_stat;
        clr_idx     = HW'(32'(wdata[HW-1:0]) % N_HARTS);
        status_word = DW'({empty, full});
    end

    always_comb begin
        stall = 1'b0;
        if (!flush) begin
            if (is_send && full[target])
                stall = 1'b1;
            if (is_recv && empty[src_hart])
                stall = 1'b1;
        end
        accept = !flush && !stall;
    end

    // Storage carries no reset: only pointers and counts define valid entries.
    always_ff @(posedge clk) begin
        if (accept && is_send)
            mem[target][wr_ptr[target]] <= wdata;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < N_HARTS; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            rdata  <= '0;
            rvalid <= 1'b0;
            led    <= '0;
        end else begin
            rvalid <= 1'b0;
            led    <= '0;
            if (accept) begin
                if (is_send) begin
                    wr_ptr[target] <= wr_ptr[target] + PW'(1);
                    count[target]  <= count[target] + CW'(1);
                    led[target]    <= 1'b1;
                end
                if (is_recv) begin
                    rdata            <= mem[src_hart][rd_ptr[src_hart]];
                    rd_ptr[src_hart] <= rd_ptr[src_hart] + PW'(1);
                    count[src_hart]  <= count[src_hart] - CW'(1);
                    rvalid           <= 1'b1;
                end
                if (is_stat) begin
                    rdata  <= status_word;
                    rvalid <= 1'b1;
                end
                if (is_other_rd) begin
                    rdata  <= '0;
                    rvalid <= 1'b1;
                end
                if (is_clr) begin
                    wr_ptr[clr_idx] <= '0;
                    rd_ptr[clr_idx] <= '0;
                    count[clr_idx]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hart_mailbox.sv
// Scoreboard bench for hart_mailbox: reads push expected responses, a monitor
// pops them whenever rvalid is seen; flags, stall and led are checked directly.
module tb_hart_mailbox;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int HW = 2;

    logic          clk = 1'b0;
    logic          nReset;
    logic          wr_en, rd_en, flush;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [HW-1:0] src_hart;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic [N-1:0]  full, empty, led;

    typedef struct {
        logic [DW-1:0] data;
        int            cycle;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    hart_mailbox #(.N_HARTS(N), .DW(DW), .DEPTH(4), .ADDR_W(AW)) dut (
        .clk(clk), .nReset(nReset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .src_hart(src_hart), .flush(flush), .stall(stall),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty), .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Every rvalid must match the oldest outstanding read, in data and in timing.
    always @(negedge clk) begin
        if (nReset && rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid: actual rdata=0x%0h required=no response", rdata);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.name, "_data"}, 64'(rdata), 64'(mon_e.data));
                checkOutput({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cycle));
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic r, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [HW-1:0] s, input logic f);
        wr_en = w; rd_en = r; addr = a; wdata = d; src_hart = s; flush = f;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic sendWord(input logic [HW-1:0] s, input logic [AW-1:0] mbox, input logic [DW-1:0] d);
        logic [N-1:0] exp_led;
        exp_led = 4'b0001 << mbox[1:0];
        applyStimulus(1'b1, 1'b0, mbox, d, s, 1'b0);
        @(negedge clk);
        checkOutput("send_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        checkOutput("send_led", 64'(led), 64'(exp_led));
        idleInputs();
    endtask

    task automatic readReq(input logic [AW-1:0] a, input logic [HW-1:0] s,
                           input logic [DW-1:0] expected, input string name);
        sb.push_back('{data: expected, cycle: cyc + 1, name: name});
        applyStimulus(1'b0, 1'b1, a, '0, s, 1'b0);
        @(negedge clk);
        checkOutput({name, "_stall"}, 64'(stall), 64'd0);
        @(posedge clk); #1;
        idleInputs();
    endtask

    task automatic clearBox(input logic [DW-1:0] idx);
        applyStimulus(1'b1, 1'b0, AW'(N + 2), idx, '0, 1'b0);
        @(negedge clk);
        checkOutput("clear_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        checkOutput("clear_led", 64'(led), 64'd0);
        idleInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nReset = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #3 nReset = 1'b1;
        @(negedge clk);
        checkOutput("reset_empty", 64'(empty), 64'hF);
        checkOutput("reset_full", 64'(full), 64'h0);
        checkOutput("reset_stall", 64'(stall), 64'h0);
        checkOutput("reset_rdata", 64'(rdata), 64'h0);
        checkOutput("reset_rvalid", 64'(rvalid), 64'h0);
        checkOutput("reset_led", 64'(led), 64'h0);
        @(posedge clk); #1;

        // Basic send/receive through mailbox 2
        sendWord(2'd1, 8'd2, 32'hA1);
        sendWord(2'd1, 8'd2, 32'hA2);
        checkOutput("pair_empty", 64'(empty), 64'hB);
        readReq(AW'(N), 2'd2, 32'hA1, "recv_a1");
        readReq(AW'(N), 2'd2, 32'hA2, "recv_a2");
        checkOutput("pair_drained", 64'(empty), 64'hF);

        // Fill mailbox 0, hold a blocked fifth send, then free one slot
        for (int i = 0; i < 4; i++)
            sendWord(2'd3, 8'd0, 32'h10 + 32'(i));
        checkOutput("fill_full", 64'(full), 64'h1);
        checkOutput("fill_empty", 64'(empty), 64'hE);
        applyStimulus(1'b1, 1'b0, 8'd0, 32'hFF, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("full_stall", 64'(stall), 64'd1);
            @(posedge clk); #1;
            checkOutput("full_stall_led", 64'(led), 64'd0);
        end
        idleInputs();
        checkOutput("full_held", 64'(full), 64'h1);
        readReq(AW'(N), 2'd0, 32'h10, "pop_10");
        sendWord(2'd3, 8'd0, 32'hFF);
        readReq(AW'(N), 2'd0, 32'h11, "pop_11");
        readReq(AW'(N), 2'd0, 32'h12, "pop_12");
        readReq(AW'(N), 2'd0, 32'h13, "pop_13");
        readReq(AW'(N), 2'd0, 32'hFF, "pop_ff");
        checkOutput("fifo0_drained", 64'(empty), 64'hF);
        @(posedge clk); #1;

        // Empty-mailbox receive stalls; flush cancels it
        applyStimulus(1'b0, 1'b1, AW'(N), '0, 2'd3, 1'b0);
        @(negedge clk);
        checkOutput("empty_stall", 64'(stall), 64'd1);
        checkOutput("empty_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_stall", 64'(stall), 64'd0);
        checkOutput("flush_rvalid_prev", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        checkOutput("flush_rvalid", 64'(rvalid), 64'd0);
        checkOutput("flush_empty", 64'(empty), 64'hF);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 8'd1, 32'hDEAD, 2'd0, 1'b1);
        @(negedge clk);
        checkOutput("flush_send_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        checkOutput("flush_send_led", 64'(led), 64'd0);
        checkOutput("flush_send_empty", 64'(empty), 64'hF);
        idleInputs();

        // Pointer wrap on mailbox 1
        for (int v = 1; v <= 6; v++) begin
            sendWord(2'd0, 8'd1, 32'(v));
            readReq(AW'(N), 2'd1, 32'(v), "wrap");
        end

        // Status, combined read/write, unmapped addresses, clear
        for (int i = 0; i < 4; i++)
            sendWord(2'd1, 8'd0, 32'h20 + 32'(i));
        sendWord(2'd2, 8'd3, 32'h30);
        readReq(AW'(N + 1), 2'd0, 32'h61, "status");
        applyStimulus(1'b1, 1'b1, AW'(N), 32'h99, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("rw_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        checkOutput("rw_led", 64'(led), 64'd0);
        idleInputs();
        checkOutput("rw_empty", 64'(empty), 64'h6);
        checkOutput("rw_full", 64'(full), 64'h1);
        readReq(8'd9, 2'd1, 32'h0, "other_read");
        applyStimulus(1'b1, 1'b0, 8'd7, 32'h1234, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("other_write_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        checkOutput("other_write_led", 64'(led), 64'd0);
        checkOutput("other_write_empty", 64'(empty), 64'h6);
        idleInputs();
        clearBox(32'd0);
        checkOutput("clear0_empty", 64'(empty), 64'h7);
        checkOutput("clear0_full", 64'(full), 64'h0);
        sendWord(2'd1, 8'd0, 32'h77);
        readReq(AW'(N), 2'd0, 32'h77, "after_clear");
        clearBox(32'd7);
        checkOutput("clear_mod_empty", 64'(empty), 64'hF);

        // rdata holds, then asynchronous reset mid-stream
        sendWord(2'd0, 8'd2, 32'h55);
        readReq(AW'(N), 2'd2, 32'h55, "recv_55");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("hold_rdata", 64'(rdata), 64'h55);
        checkOutput("hold_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        sendWord(2'd1, 8'd2, 32'h66);
        applyStimulus(1'b1, 1'b0, 8'd1, 32'hAB, 2'd1, 1'b0);
        #3 nReset = 1'b0;
        #1;
        checkOutput("midreset_empty", 64'(empty), 64'hF);
        checkOutput("midreset_full", 64'(full), 64'h0);
        checkOutput("midreset_rdata", 64'(rdata), 64'h0);
        checkOutput("midreset_rvalid", 64'(rvalid), 64'd0);
        checkOutput("midreset_led", 64'(led), 64'd0);
        idleInputs();
        @(posedge clk);
        #2 nReset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, AW'(N), '0, 2'd2, 1'b0);
        @(negedge clk);
        checkOutput("postreset_recv_stall", 64'(stall), 64'd1);
        checkOutput("postreset_empty", 64'(empty), 64'hF);
        @(posedge clk); #1;
        idleInputs();

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
